lsu: RTL and testbench

Load/store unit sitting directly downstream of the single-cycle datapath. It consumes the ALU-computed address and the store operand (`rs2` data), drives a request/acknowledge data-memory port with byte enables, and returns the aligned, sign- or zero-extended load value that the datapath writes back. It stalls the core for the full duration of each memory transaction.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 57 +++++
 rtl/lsu.sv | 108 ++++++++++
 tb/tb_lsu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: word and lane widths,
// funct3 size/sign encodings, FSM state encoding and the alignment rule
// used by the optional misalignment check.
package lsu_pkg;

    localparam int WORD = 32;
    localparam int BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_ERR
    } state_e;

    // Halfwords need an even address, words (and unknown codes) need a
    // word-aligned address; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return off[0];
            default:     return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: store byte enables and
// lane replication, and load lane extraction with sign/zero extension.
module lsu_align import lsu_pkg::*; (
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_off,
    input  logic [WORD-1:0] store_data,
    output logic [BE_W-1:0] be,
    output logic [WORD-1:0] wdata,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_off,
    input  logic [WORD-1:0] rdata,
    output logic [WORD-1:0] ldata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Store side: replicate the operand across every lane so the memory
    // only has to honour the byte enables.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (st_funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << st_off;
                wdata = {4{store_data[7:0]}};
            end
            F3_H, F3_HU: begin
                be    = 4'b0011 << {st_off[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            F3_W: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Load side: pick the addressed lane and extend it to a full word.
    always_comb begin
        byte_v = rdata[{ld_off, 3'b000} +: 8];
        half_v = ld_off[1] ? rdata[31:16] : rdata[15:0];
        ldata  = rdata;
        case (ld_funct3)
            F3_B:    ldata = {{24{byte_v[7]}}, byte_v};
            F3_BU:   ldata = {24'h000000, byte_v};
            F3_H:    ldata = {{16{half_v[15]}}, half_v};
            F3_HU:   ldata = {16'h0000, half_v};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: request/acknowledge data-memory port with byte enables,
// core stall generation and registered, formatted load data.
// Optional feature: define LSU_MISALIGN_CHECK_EN to trap misaligned
// halfword/word accesses (no memory request, one-cycle misaligned pulse).
module lsu import lsu_pkg::*; (
    input  logic            clk,
    input  logic            reset,
    input  logic            memRead,
    input  logic            memWrite,
    input  logic [2:0]      funct3,
    input  logic [WORD-1:0] addr,
    input  logic [WORD-1:0] storeData,
    output logic [WORD-1:0] loadData,
    output logic            stall,
    output logic            misaligned,
    output logic            mem_req,
    output logic            mem_we,
    output logic [WORD-1:0] mem_addr,
    output logic [BE_W-1:0] mem_be,
    output logic [WORD-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [WORD-1:0] mem_rdata
);

    state_e          state, state_nx;
    logic            op;
    logic            bad;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [BE_W-1:0] be_nx;
    logic [WORD-1:0] wdata_nx;
    logic [WORD-1:0] ld_word;

    assign op = memRead | memWrite;

`ifdef LSU_MISALIGN_CHECK_EN
    assign bad = is_misaligned(funct3, addr[1:0]);
`else
    assign bad = 1'b0;
`endif

    lsu_align u_align (
        .st_funct3 (funct3),
        .st_off    (addr[1:0]),
        .store_data(storeData),
        .be        (be_nx),
        .wdata     (wdata_nx),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .rdata     (mem_rdata),
        .ldata     (ld_word)
    );

    // State and request registers; the request is captured once in IDLE so
    // it stays stable while the memory takes its time.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            loadData  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && op && !bad) begin
                mem_we    <= memWrite;
                mem_addr  <= {addr[WORD-1:2], 2'b00};
                mem_be    <= be_nx;
                mem_wdata <= wdata_nx;
                f3_q      <= funct3;
                off_q     <= addr[1:0];
            end
            if (state == S_REQ && mem_ack && !mem_we) begin
                loadData <= ld_word;
            end
        end
    end

    // Next state and control outputs; stall is released in DONE/ERR so the
    // core commits, and forced low while reset is asserted.
    always_comb begin
        state_nx   = state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        misaligned = 1'b0;
        case (state)
            S_IDLE: begin
                stall = op & reset;
                if (op) state_nx = bad ? S_ERR : S_REQ;
            end
            S_REQ: begin
                stall   = reset;
                mem_req = 1'b1;
                if (mem_ack) state_nx = S_DONE;
            end
            S_DONE: state_nx = S_IDLE;
            S_ERR: begin
                misaligned = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: randomized and directed memory operations,
// expected responses queued by a behavioural model, checked by a monitor.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] storeData = 32'h0;
    logic [31:0] loadData;
    logic        stall;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    typedef struct {
        int          stalls;
        logic [31:0] ld;
        logic        mis;
    } done_t;

    req_t        req_q[$];
    done_t       done_q[$];
    logic [31:0] ld_model = 32'h0;
    int          n_cmp = 0;
    int          n_fail = 0;

    lsu dut (
        .clk       (clk),
        .reset     (reset),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .funct3    (funct3),
        .addr      (addr),
        .storeData (storeData),
        .loadData  (loadData),
        .stall     (stall),
        .misaligned(misaligned),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: derives lanes and load value from size and offset,
    // queues the expected request and completion, then drives the memory
    // side open-loop (ack after dly extra REQ cycles).
    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdat, input int dly);
        int          size;
        int          base;
        bit          err;
        logic [31:0] raw;
        logic [31:0] v;
        req_t        r;
        done_t       e;
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        base = (size == 1) ? int'(a[1:0]) : (size == 2) ? (int'(a[1:0]) & 2) : 0;
        err  = CHK_EN && ((size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00));
        r.addr  = a & 32'hFFFF_FFFC;
        r.be    = 4'(((1 << size) - 1) << base);
        r.wdata = (size == 1) ? {4{sd[7:0]}} : (size == 2) ? {2{sd[15:0]}} : sd;
        r.we    = wr;
        raw = rdat >> (8 * base);
        if (size == 1) begin
            v = raw & 32'h0000_00FF;
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
            v = raw & 32'h0000_FFFF;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rdat;
        end
        if (!err && !wr) ld_model = v;
        e.stalls = err ? 1 : dly + 2;
        e.ld     = ld_model;
        e.mis    = err;
        if (!err) req_q.push_back(r);
        done_q.push_back(e);

        memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = sd; mem_ack = 1'b0;
        if (err) begin
            tick();
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            tick();
        end else begin
            for (int n = 1; n <= dly + 1; n++) begin
                tick();
                addr = $urandom; storeData = $urandom; funct3 = 3'($urandom);
                mem_ack   = (n == dly + 1);
                mem_rdata = (n == dly + 1) ? rdat : $urandom;
            end
            tick();
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            tick();
        end
        memRead = 1'b0; memWrite = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic idle_gap(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            mem_ack   = stray ? 1'($urandom) : 1'b0;
            mem_rdata = $urandom;
            tick();
        end
        mem_ack = 1'b0;
    endtask

    // Monitor: pops the expected request when mem_req rises and holds it
    // for the whole request; pops the expected completion when stall drops.
    initial begin
        int    cnt;
        bit    prev;
        req_t  cur;
        done_t e;
        cnt = 0;
        prev = 1'b0;
        cur = '{addr: 32'h0, be: 4'h0, wdata: 32'h0, we: 1'b0};
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt  = 0;
                prev = 1'b0;
            end else begin
                if (mem_req) begin
                    if (!prev) begin
                        if (req_q.size() == 0) begin
                            n_cmp++; n_fail++;
                            $display("FAIL unexpected_req: got mem_req=1 at addr %h, expected no request", mem_addr);
                        end else begin
                            cur = req_q.pop_front();
                        end
                    end
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_be", 32'(mem_be), 32'(cur.be));
                    chk("mem_wdata", mem_wdata, cur.wdata);
                    chk("mem_we", 32'(mem_we), 32'(cur.we));
                end
                prev = mem_req;
                if (stall) begin
                    cnt++;
                end else if (cnt > 0) begin
                    if (done_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_done: got completion after %0d stall cycles, expected none", cnt);
                    end else begin
                        e = done_q.pop_front();
                        chk("stall_cycles", 32'(cnt), 32'(e.stalls));
                        chk("loadData", loadData, e.ld);
                        chk("misaligned", 32'(misaligned), 32'(e.mis));
                    end
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of stimulus, expected $finish");
        $fatal(1);
    end

    initial begin
        // Reset state, with a pending op that must not raise stall.
        reset = 1'b0; memRead = 1'b1; addr = 32'h104; funct3 = 3'b010;
        tick(); tick(); tick();
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_loadData", loadData, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'h0);
        memRead = 1'b0;
        reset = 1'b1;
        tick();

        // Directed cases.
        do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
        do_op(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80AABBCC, 0);
        do_op(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80AABBCC, 0);
        do_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 1);
        do_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'hF00DBEEF, 2);
        do_op(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h1234ABCD, 1);
        idle_gap(1, 1'b0);

        // Reset during REQ: request abandoned, loadData cleared, late ack ignored.
        req_q.push_back('{addr: 32'h300, be: 4'hF, wdata: 32'hCAFEF00D, we: 1'b0});
        memRead = 1'b1; funct3 = 3'b010; addr = 32'h300; storeData = 32'hCAFEF00D;
        tick();
        tick();
        reset = 1'b0; memRead = 1'b0;
        tick();
        reset = 1'b1;
        ld_model = 32'h0;
        chk("rstreq_mem_req", 32'(mem_req), 32'h0);
        chk("rstreq_loadData", loadData, 32'h0);
        chk("rstreq_stall", 32'(stall), 32'h0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("lateack_loadData", loadData, 32'h0);
        chk("lateack_mem_req", 32'(mem_req), 32'h0);
        chk("lateack_stall", 32'(stall), 32'h0);

        // Back-to-back load then store (both strobes high), then stray acks in IDLE.
        do_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h55AA33CC, 0);
        do_op(1'b1, 1'b1, 3'b010, 32'h44, 32'h01020304, 32'hFFFFFFFF, 0);
        idle_gap(3, 1'b1);
        do_op(1'b1, 1'b0, 3'b001, 32'h46, 32'h0, 32'h8001_7FFF, 0);

        // Randomized operations.
        for (int i = 0; i < 300; i++) begin
            int          kind;
            bit          rd;
            bit          wr;
            logic [2:0]  f3;
            kind = int'($urandom_range(0, 3));
            rd = (kind != 2);
            wr = (kind >= 2);
            f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            do_op(rd, wr, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
            idle_gap(int'($urandom_range(0, 2)), 1'b1);
        end

        idle_gap(4, 1'b0);
        chk("req_q_left", 32'(req_q.size()), 32'h0);
        chk("done_q_left", 32'(done_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
